// File: rtl/aes_ocl_pkg.sv
// Shared constants, register decode and state types
// for the AES-256 OCL control slice.
package aes_ocl_pkg;

  localparam logic [31:0] ADDR_KEY0   = 32'h00;
  localparam logic [31:0] ADDR_PT0    = 32'h20;
  localparam logic [31:0] ADDR_CTRL   = 32'h30;
  localparam logic [31:0] ADDR_STATUS = 32'h34;
  localparam logic [31:0] ADDR_CT0    = 32'h40;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_ERR  = 2;

  localparam int CTRL_START   = 0;
  localparam int CTRL_CLR_ERR = 1;

  localparam logic [31:0] UNIMPL_VAL = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } op_state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_e;

  typedef enum logic [2:0] {
    SEL_KEY,
    SEL_PT,
    SEL_CTRL,
    SEL_STAT,
    SEL_CT,
    SEL_NONE
  } reg_sel_e;

  typedef struct packed {
    reg_sel_e   sel;
    logic [2:0] idx;
  } reg_dec_t;

  // Only word-aligned accesses map onto a register.
  function automatic reg_dec_t addr_dec(
    input logic [31:0] a
  );
    reg_dec_t d;
    logic     al;
    al    = (a[1:0] == 2'b00);
    d.sel = SEL_NONE;
    d.idx = a[4:2];
    unique case (1'b1)
      (al && a[31:5] == ADDR_KEY0[31:5]):
        d.sel = SEL_KEY;
      (al && a[31:4] == ADDR_PT0[31:4]): begin
        d.sel = SEL_PT;
        d.idx = {1'b0, a[3:2]};
      end
      (al && a[31:2] == ADDR_CTRL[31:2]):
        d.sel = SEL_CTRL;
      (al && a[31:2] == ADDR_STATUS[31:2]):
        d.sel = SEL_STAT;
      (al && a[31:4] == ADDR_CT0[31:4]): begin
        d.sel = SEL_CT;
        d.idx = {1'b0, a[3:2]};
      end
      default:
        d.sel = SEL_NONE;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/aes_ocl_axil_slv.sv
// AXI-Lite slave: one write and one read in flight,
// register decode and registered read mux.
module aes_ocl_axil_slv
  import aes_ocl_pkg::*;
#(
  parameter logic [31:0] RD_UNIMPL = 32'hDEAD_BEEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             awvalid,
  output logic             awready,
  input  logic [31:0]      awaddr,
  input  logic             wvalid,
  output logic             wready,
  input  logic [31:0]      wdata,
  input  logic [3:0]       wstrb,
  output logic             bvalid,
  input  logic             bready,
  output logic [1:0]       bresp,
  input  logic             arvalid,
  output logic             arready,
  input  logic [31:0]      araddr,
  output logic             rvalid,
  input  logic             rready,
  output logic [31:0]      rdata,
  output logic [1:0]       rresp,
  input  logic [7:0][31:0] i_key,
  input  logic [3:0][31:0] i_pt,
  input  logic [3:0][31:0] i_ct,
  input  logic [2:0]       i_status,
  output logic             o_wr_en,
  output reg_sel_e         o_wr_sel,
  output logic [2:0]       o_wr_idx,
  output logic [31:0]      o_wr_data,
  output logic [3:0]       o_wr_strb
);

  wr_state_e   r_wst;
  wr_state_e   w_wst_nxt;
  logic        r_rdy;
  logic [31:0] r_awaddr;
  logic        r_rvalid;
  logic [31:0] r_rdata;
  reg_dec_t    w_wdec;
  reg_dec_t    w_rdec;
  logic [31:0] w_rd_mux;
  logic        w_aw_hs;
  logic        w_w_hs;
  logic        w_ar_hs;

  // Holds both address channels off for the reset cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rdy <= 1'b0;
    else        r_rdy <= 1'b1;
  end

  assign awready = r_rdy && (r_wst == W_IDLE);
  assign wready  = (r_wst == W_DATA);
  assign bvalid  = (r_wst == W_RESP);
  assign bresp   = 2'b00;
  assign w_aw_hs = awvalid && awready;
  assign w_w_hs  = wvalid && wready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wst    <= W_IDLE;
      r_awaddr <= '0;
    end else begin
      r_wst <= w_wst_nxt;
      if (w_aw_hs) r_awaddr <= awaddr;
    end
  end

  always_comb begin
    w_wst_nxt = r_wst;
    unique case (r_wst)
      W_IDLE: if (w_aw_hs) w_wst_nxt = W_DATA;
      W_DATA: if (w_w_hs)  w_wst_nxt = W_RESP;
      W_RESP: if (bready)  w_wst_nxt = W_IDLE;
      default:             w_wst_nxt = W_IDLE;
    endcase
  end

  assign w_wdec    = addr_dec(r_awaddr);
  assign o_wr_en   = w_w_hs;
  assign o_wr_sel  = w_wdec.sel;
  assign o_wr_idx  = w_wdec.idx;
  assign o_wr_data = wdata;
  assign o_wr_strb = wstrb;

  assign arready = r_rdy && !r_rvalid;
  assign w_ar_hs = arvalid && arready;
  assign w_rdec  = addr_dec(araddr);

  always_comb begin
    w_rd_mux = RD_UNIMPL;
    unique case (w_rdec.sel)
      SEL_KEY:  w_rd_mux = i_key[w_rdec.idx];
      SEL_PT:   w_rd_mux = i_pt[w_rdec.idx[1:0]];
      SEL_CTRL: w_rd_mux = '0;
      SEL_STAT: w_rd_mux = {29'd0, i_status};
      SEL_CT:   w_rd_mux = i_ct[w_rdec.idx[1:0]];
      default:  w_rd_mux = RD_UNIMPL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rd_mux;
    end else if (r_rvalid && rready) begin
      r_rvalid <= 1'b0;
    end
  end

  assign rvalid = r_rvalid;
  assign rdata  = r_rdata;
  assign rresp  = 2'b00;

endmodule

// File: rtl/aes_ocl_ctrl.sv
// Control block feeding an external AES-256 core:
// operand registers, run/done sequencing, status.
module aes_ocl_ctrl #(
  parameter int          AES_LATENCY = 29,
  parameter logic [31:0] UNIMPL_VAL  = aes_ocl_pkg::UNIMPL_VAL
) (
  input  logic         clk_main_a0,
  input  logic         rst_main_n,
  input  logic         awvalid,
  output logic         awready,
  input  logic [31:0]  awaddr,
  input  logic         wvalid,
  output logic         wready,
  input  logic [31:0]  wdata,
  input  logic [3:0]   wstrb,
  output logic         bvalid,
  input  logic         bready,
  output logic [1:0]   bresp,
  input  logic         arvalid,
  output logic         arready,
  input  logic [31:0]  araddr,
  output logic         rvalid,
  input  logic         rready,
  output logic [31:0]  rdata,
  output logic [1:0]   rresp,
  output logic [127:0] aes_state,
  output logic [255:0] aes_key,
  input  logic [127:0] aes_out,
  output logic         done_pulse,
  output logic [15:0]  vled
);
  import aes_ocl_pkg::*;

  localparam int CW =
    (AES_LATENCY < 1) ? 1 : $clog2(AES_LATENCY + 1);
  localparam logic [CW-1:0] LAT = CW'(AES_LATENCY);

  logic [1:0]       r_rst_sync;
  logic             w_rst_n;
  op_state_e        r_st;
  op_state_e        w_st_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [7:0][31:0] r_key;
  logic [3:0][31:0] r_pt;
  logic [3:0][31:0] r_ct;
  logic             r_done;
  logic             r_err;
  logic [15:0]      r_vled;
  logic             w_wr_en;
  reg_sel_e         w_wr_sel;
  logic [2:0]       w_wr_idx;
  logic [31:0]      w_wr_data;
  logic [3:0]       w_wr_strb;
  logic             w_ctrl_wr;
  logic             w_start;
  logic             w_clr;
  logic             w_run;
  logic             w_fin;
  logic             w_go;
  logic             w_kp_wr;
  logic             w_set_err;
  logic [2:0]       w_status;

  // Assert asynchronously, release two edges later.
  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) r_rst_sync <= 2'b00;
    else             r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n = r_rst_sync[1];

  aes_ocl_axil_slv #(
    .RD_UNIMPL (UNIMPL_VAL)
  ) u_slv (
    .clk       (clk_main_a0),
    .rst_n     (w_rst_n),
    .awvalid   (awvalid),
    .awready   (awready),
    .awaddr    (awaddr),
    .wvalid    (wvalid),
    .wready    (wready),
    .wdata     (wdata),
    .wstrb     (wstrb),
    .bvalid    (bvalid),
    .bready    (bready),
    .bresp     (bresp),
    .arvalid   (arvalid),
    .arready   (arready),
    .araddr    (araddr),
    .rvalid    (rvalid),
    .rready    (rready),
    .rdata     (rdata),
    .rresp     (rresp),
    .i_key     (r_key),
    .i_pt      (r_pt),
    .i_ct      (r_ct),
    .i_status  (w_status),
    .o_wr_en   (w_wr_en),
    .o_wr_sel  (w_wr_sel),
    .o_wr_idx  (w_wr_idx),
    .o_wr_data (w_wr_data),
    .o_wr_strb (w_wr_strb)
  );

  assign w_ctrl_wr = w_wr_en && (w_wr_sel == SEL_CTRL)
                     && w_wr_strb[0];
  assign w_start   = w_ctrl_wr && w_wr_data[CTRL_START];
  assign w_clr     = w_ctrl_wr && w_wr_data[CTRL_CLR_ERR];
  assign w_run     = (r_st == S_RUN);
  assign w_fin     = w_run && (r_cnt == '0);
  assign w_go      = w_start && !w_run;
  assign w_kp_wr   = w_wr_en && ((w_wr_sel == SEL_KEY) ||
                                 (w_wr_sel == SEL_PT));
  assign w_set_err = w_run && (w_start || w_kp_wr);

  always_comb begin
    w_status            = '0;
    w_status[STAT_BUSY] = w_run;
    w_status[STAT_DONE] = r_done;
    w_status[STAT_ERR]  = r_err;
  end

  always_comb begin
    w_st_nxt  = r_st;
    w_cnt_nxt = r_cnt;
    unique case (r_st)
      S_IDLE, S_DONE: begin
        if (w_start) begin
          w_st_nxt  = S_RUN;
          w_cnt_nxt = LAT;
        end
      end
      S_RUN: begin
        if (r_cnt == '0) w_st_nxt  = S_DONE;
        else             w_cnt_nxt = r_cnt - 1'b1;
      end
      default: w_st_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_main_a0 or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_st   <= S_IDLE;
      r_cnt  <= '0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_st  <= w_st_nxt;
      r_cnt <= w_cnt_nxt;
      if (w_go)       r_done <= 1'b0;
      else if (w_fin) r_done <= 1'b1;
      // START is judged first, so CLR_ERR wins.
      if (w_clr)          r_err <= 1'b0;
      else if (w_set_err) r_err <= 1'b1;
    end
  end

  always_ff @(posedge clk_main_a0 or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_key  <= '0;
      r_pt   <= '0;
      r_ct   <= '0;
      r_vled <= '0;
    end else begin
      if (w_fin) begin
        r_ct   <= aes_out;
        r_vled <= aes_out[15:0];
      end
      if (w_wr_en && !w_run) begin
        for (int b = 0; b < 4; b++) begin
          if (w_wr_strb[b]) begin
            if (w_wr_sel == SEL_KEY)
              r_key[w_wr_idx][8*b +: 8] <=
                w_wr_data[8*b +: 8];
            if (w_wr_sel == SEL_PT)
              r_pt[w_wr_idx[1:0]][8*b +: 8] <=
                w_wr_data[8*b +: 8];
          end
        end
      end
    end
  end

  assign aes_key    = r_key;
  assign aes_state  = r_pt;
  assign done_pulse = w_fin;
  assign vled       = r_vled;

endmodule

// File: tb/tb_aes_ocl_ctrl.sv
// Scenario bench for aes_ocl_ctrl with a behavioural
// AES core stand-in and a read-data scoreboard.
module tb_aes_ocl_ctrl;

  localparam int LAT = 29;
  localparam logic [255:0] FK =
    256'h000102030405060708090a0b0c0d0e0f_101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] FP =
    128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FC =
    128'h8ea2b7ca516745bfeafc49904b496089;

  logic         clk_main_a0 = 1'b0;
  logic         rst_main_n  = 1'b0;
  logic         awvalid = 0, wvalid = 0, bready = 0;
  logic         arvalid = 0, rready = 0;
  logic [31:0]  awaddr = 0, wdata = 0, araddr = 0;
  logic [3:0]   wstrb = 0;
  logic         awready, wready, bvalid, arready, rvalid;
  logic [1:0]   bresp, rresp;
  logic [31:0]  rdata;
  logic [127:0] aes_state, aes_out;
  logic [255:0] aes_key;
  logic         done_pulse;
  logic [15:0]  vled;

  int vecs = 0;
  int miscompares = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;

  logic [31:0]  exp_q[$];
  string        nm_q[$];
  logic [31:0]  sb_exp;
  string        sb_nm;
  logic [255:0] sk;
  logic [127:0] sp;
  logic [127:0] ect;

  // Stand-in core: FIPS-197 C.3 vector, else a mix.
  function automatic logic [127:0] core(
    input logic [255:0] k, input logic [127:0] s);
    if (k === FK && s === FP) return FC;
    return s ^ k[127:0] ^ k[255:128]
           ^ 128'hA5A5_5A5A_0F0F_F0F0_3C3C_C3C3_9696_6969;
  endfunction

  assign aes_out = core(aes_key, aes_state);

  aes_ocl_ctrl #(.AES_LATENCY(LAT)) dut (
    .clk_main_a0 (clk_main_a0),
    .rst_main_n  (rst_main_n),
    .awvalid     (awvalid),
    .awready     (awready),
    .awaddr      (awaddr),
    .wvalid      (wvalid),
    .wready      (wready),
    .wdata       (wdata),
    .wstrb       (wstrb),
    .bvalid      (bvalid),
    .bready      (bready),
    .bresp       (bresp),
    .arvalid     (arvalid),
    .arready     (arready),
    .araddr      (araddr),
    .rvalid      (rvalid),
    .rready      (rready),
    .rdata       (rdata),
    .rresp       (rresp),
    .aes_state   (aes_state),
    .aes_key     (aes_key),
    .aes_out     (aes_out),
    .done_pulse  (done_pulse),
    .vled        (vled)
  );

  always #5 clk_main_a0 = ~clk_main_a0;

  always @(posedge clk_main_a0) cyc <= cyc + 1;

  always @(negedge clk_main_a0) begin
    if (done_pulse === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // Scoreboard: one expected word per read, in order.
  always @(negedge clk_main_a0) begin
    if (rvalid === 1'b1 && rready === 1'b1) begin
      vecs++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL sb_underflow: got %h expected none",
                 rdata);
      end else begin
        sb_exp = exp_q.pop_front();
        sb_nm  = nm_q.pop_front();
        if (rdata !== sb_exp || rresp !== 2'b00) begin
          miscompares++;
          $display("FAIL %s: got %h/%0d expected %h/0",
                   sb_nm, rdata, rresp, sb_exp);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic wr(input logic [31:0] a,
                    input logic [31:0] d,
                    input logic [3:0]  s,
                    output int         hs);
    int n;
    awaddr = a; awvalid = 1'b1; n = 0;
    while (awready !== 1'b1 && n < 50) begin
      @(posedge clk_main_a0); #1; n++;
    end
    @(posedge clk_main_a0); #1;
    awvalid = 1'b0;
    wdata = d; wstrb = s; wvalid = 1'b1;
    while (wready !== 1'b1 && n < 50) begin
      @(posedge clk_main_a0); #1; n++;
    end
    hs = cyc;
    @(posedge clk_main_a0); #1;
    wvalid = 1'b0; bready = 1'b1;
    vecs++;
    if (n >= 50 || bvalid !== 1'b1 || bresp !== 2'b00) begin
      miscompares++;
      $display("FAIL wr_resp %h: got bvalid=%b bresp=%0d expected 1/0",
               a, bvalid, bresp);
    end
    @(posedge clk_main_a0); #1;
    bready = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a,
                    input logic [31:0] e,
                    input string       nm);
    int n;
    exp_q.push_back(e); nm_q.push_back(nm);
    araddr = a; arvalid = 1'b1; n = 0;
    while (arready !== 1'b1 && n < 50) begin
      @(posedge clk_main_a0); #1; n++;
    end
    @(posedge clk_main_a0); #1;
    arvalid = 1'b0;
    vecs++;
    if (rvalid !== 1'b1 || n >= 50) begin
      miscompares++;
      $display("FAIL %s_rlat: got rvalid=%b expected 1",
               nm, rvalid);
      void'(exp_q.pop_back()); void'(nm_q.pop_back());
    end else begin
      rready = 1'b1;
      @(posedge clk_main_a0); #1;
      rready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_main_n = 1'b0;
    repeat (3) @(posedge clk_main_a0);
    #1;
    vecs++;
    if ({awready, arready, bvalid, rvalid, done_pulse} !== 5'b0) begin
      miscompares++;
      $display("FAIL rst_hs: got %b expected 00000",
               {awready, arready, bvalid, rvalid, done_pulse});
    end
    vecs++;
    if (aes_key !== '0 || aes_state !== '0 ||
        vled !== '0 || rdata !== '0) begin
      miscompares++;
      $display("FAIL rst_regs: got vled=%h rdata=%h expected 0",
               vled, rdata);
    end
    rst_main_n = 1'b1;
    vecs++;
    if (awready !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_release: got awready=%b expected 0",
               awready);
    end
    repeat (4) @(posedge clk_main_a0);
    #1;
    rd(32'h34, 32'h0, "rst_status");
    rd(32'h40, 32'h0, "rst_ct0");
    rd(32'h00, 32'h0, "rst_key0");
  endtask

  task automatic test_fips();
    int h, hs, d0, n;
    sk = FK; sp = FP;
    for (int i = 0; i < 8; i++)
      wr(32'(4 * i), sk[32*i +: 32], 4'hF, h);
    for (int i = 0; i < 4; i++)
      wr(32'h20 + 32'(4 * i), sp[32*i +: 32], 4'hF, h);
    vecs++;
    if (aes_key !== sk || aes_state !== sp) begin
      miscompares++;
      $display("FAIL fips_operands: got %h expected %h",
               aes_state, sp);
    end
    d0 = done_cnt; ect = FC;
    wr(32'h30, 32'h1, 4'hF, hs);
    n = 0;
    while (done_cnt == d0 && n < 200) begin
      @(posedge clk_main_a0); #1; n++;
    end
    repeat (3) @(posedge clk_main_a0);
    #1;
    vecs++;
    if (done_cnt != d0 + 1 || done_cyc - hs != LAT + 1) begin
      miscompares++;
      $display("FAIL fips_latency: got %0d pulses at +%0d expected 1 at +%0d",
               done_cnt - d0, done_cyc - hs, LAT + 1);
    end
    for (int i = 0; i < 4; i++)
      rd(32'h40 + 32'(4 * i), ect[32*i +: 32], "fips_ct");
    rd(32'h34, 32'h2, "fips_status");
    vecs++;
    if (vled !== 16'h6089) begin
      miscompares++;
      $display("FAIL fips_vled: got %h expected 6089", vled);
    end
  endtask

  task automatic test_err();
    int h, hs, d0, n;
    sp[31:0] = 32'h1234_5678;
    wr(32'h20, 32'h1234_5678, 4'hF, h);
    d0 = done_cnt; ect = core(sk, sp);
    wr(32'h30, 32'h1, 4'hF, hs);
    wr(32'h30, 32'h1, 4'hF, h);
    rd(32'h34, 32'h5, "err_start_in_run");
    wr(32'h00, 32'hFFFF_FFFF, 4'hF, h);
    vecs++;
    if (aes_key !== sk) begin
      miscompares++;
      $display("FAIL err_key_frozen: got %h expected %h",
               aes_key[31:0], sk[31:0]);
    end
    n = 0;
    while (done_cnt == d0 && n < 200) begin
      @(posedge clk_main_a0); #1; n++;
    end
    vecs++;
    if (done_cnt != d0 + 1 || done_cyc - hs != LAT + 1) begin
      miscompares++;
      $display("FAIL err_latency: got +%0d expected +%0d",
               done_cyc - hs, LAT + 1);
    end
    rd(32'h34, 32'h6, "err_done_status");
    for (int i = 0; i < 4; i++)
      rd(32'h40 + 32'(4 * i), ect[32*i +: 32], "err_ct");
    rd(32'h00, sk[31:0], "err_key0");
    wr(32'h30, 32'h2, 4'hF, h);
    rd(32'h34, 32'h2, "err_clr");
    d0 = done_cnt;
    wr(32'h30, 32'h1, 4'hF, hs);
    wr(32'h30, 32'h3, 4'hF, h);
    rd(32'h34, 32'h1, "err_start_clr");
    n = 0;
    while (done_cnt == d0 && n < 200) begin
      @(posedge clk_main_a0); #1; n++;
    end
    rd(32'h34, 32'h2, "err_final");
  endtask

  task automatic test_status_race();
    int hs, n;
    wr(32'h30, 32'h1, 4'hF, hs);
    n = 0;
    while (cyc < hs + LAT + 1 && n < 200) begin
      @(posedge clk_main_a0); #1; n++;
    end
    vecs++;
    if (done_pulse !== 1'b1) begin
      miscompares++;
      $display("FAIL race_align: got done_pulse=%b expected 1",
               done_pulse);
    end
    rd(32'h34, 32'h1, "race_pre");
    rd(32'h34, 32'h2, "race_post");
  endtask

  task automatic test_strobe();
    int h;
    wr(32'h20, 32'h0, 4'hF, h);
    wr(32'h20, 32'hAABB_CCDD, 4'b0010, h);
    sp[31:0] = 32'h0000_CC00;
    rd(32'h20, 32'h0000_CC00, "strb_pt0");
    wr(32'h1C, 32'h1122_3344, 4'b1001, h);
    sk[255:224] = 32'h1101_0244;
    rd(32'h1C, 32'h1101_0244, "strb_key7");
  endtask

  task automatic test_unmapped();
    int h, n;
    logic [31:0] d0;
    araddr = 32'h100; arvalid = 1'b1; n = 0;
    while (arready !== 1'b1 && n < 50) begin
      @(posedge clk_main_a0); #1; n++;
    end
    @(posedge clk_main_a0); #1;
    arvalid = 1'b0;
    d0 = rdata;
    vecs++;
    if (rvalid !== 1'b1 || d0 !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL unmap_first: got %b/%h expected 1/deadbeef",
               rvalid, d0);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_main_a0); #1;
      vecs++;
      if (rvalid !== 1'b1 || rdata !== 32'hDEAD_BEEF ||
          arready !== 1'b0) begin
        miscompares++;
        $display("FAIL unmap_hold%0d: got %b/%h/%b expected 1/deadbeef/0",
                 i, rvalid, rdata, arready);
      end
    end
    exp_q.push_back(32'hDEAD_BEEF); nm_q.push_back("unmap_data");
    rready = 1'b1;
    @(posedge clk_main_a0); #1;
    rready = 1'b0;
    wr(32'h100, 32'h1234_5678, 4'hF, h);
    wr(32'h34, 32'h7, 4'hF, h);
    wr(32'h40, 32'h0, 4'hF, h);
    rd(32'h34, 32'h2, "ro_status");
    rd(32'h40, ect[31:0], "ro_ct0");
    rd(32'h30, 32'h0, "ctrl_reads0");
  endtask

  task automatic test_back_to_back();
    int h, d0, n;
    logic [31:0] v;
    for (int i = 0; i < 8; i++) begin
      v = $urandom;
      sk[32*i +: 32] = v;
      wr(32'(4 * i), v, 4'hF, h);
    end
    for (int i = 0; i < 4; i++) begin
      v = $urandom;
      sp[32*i +: 32] = v;
      wr(32'h20 + 32'(4 * i), v, 4'hF, h);
    end
    for (int i = 0; i < 8; i++)
      rd(32'(4 * i), sk[32*i +: 32], "b2b_key");
    for (int i = 0; i < 4; i++)
      rd(32'h20 + 32'(4 * i), sp[32*i +: 32], "b2b_pt");
    d0 = done_cnt; ect = core(sk, sp);
    wr(32'h30, 32'h1, 4'hF, h);
    n = 0;
    while (done_cnt == d0 && n < 200) begin
      @(posedge clk_main_a0); #1; n++;
    end
    @(posedge clk_main_a0); #1;
    for (int i = 0; i < 4; i++)
      rd(32'h40 + 32'(4 * i), ect[32*i +: 32], "b2b_ct");
    vecs++;
    if (vled !== ect[15:0]) begin
      miscompares++;
      $display("FAIL b2b_vled: got %h expected %h",
               vled, ect[15:0]);
    end
  endtask

  task automatic test_reset_mid_run();
    int hs, d0, n;
    d0 = done_cnt;
    wr(32'h30, 32'h1, 4'hF, hs);
    n = 0;
    while (cyc < hs + 11 && n < 50) begin
      @(posedge clk_main_a0); #1; n++;
    end
    rst_main_n = 1'b0;
    repeat (3) @(posedge clk_main_a0);
    #1;
    rst_main_n = 1'b1;
    repeat (LAT + 10) @(posedge clk_main_a0);
    #1;
    vecs++;
    if (done_cnt != d0) begin
      miscompares++;
      $display("FAIL abort_pulse: got %0d pulses expected 0",
               done_cnt - d0);
    end
    rd(32'h34, 32'h0, "abort_status");
    rd(32'h40, 32'h0, "abort_ct0");
    rd(32'h00, 32'h0, "abort_key0");
    vecs++;
    if (vled !== 16'h0) begin
      miscompares++;
      $display("FAIL abort_vled: got %h expected 0", vled);
    end
  endtask

  initial begin
    @(posedge clk_main_a0); #1;
    test_reset();
    test_fips();
    test_err();
    test_status_race();
    test_strobe();
    test_unmapped();
    test_back_to_back();
    test_reset_mid_run();
    vecs++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL sb_leftover: got %0d expected 0",
               exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, miscompares);
    $finish;
  end

endmodule

// File: doc/aes_ocl_ctrl.md
AES_OCL_CTRL -- requirements
Module: aes_ocl_ctrl

Interface
REQ-001 Parameter AES_LATENCY, default 29: clk_main_a0 cycles from stable aes_state/aes_key to valid aes_out.
REQ-002 Parameter UNIMPL_VAL, default 32'hDEAD_BEEF: read data returned for unmapped addresses.
REQ-003 clk_main_a0  in  1  clock; all logic is on the rising edge.
REQ-004 rst_main_n  in  1  reset, asynchronous, active-low.
REQ-005 awvalid/awready  in/out  1/1, awaddr  in  32: AXI-Lite write address.
REQ-006 wvalid/wready  in/out  1/1, wdata  in  32, wstrb  in  4: AXI-Lite write data.
REQ-007 bvalid/bready  out/in  1/1, bresp  out  2: AXI-Lite write response.
REQ-008 arvalid/arready  in/out  1/1, araddr  in  32: AXI-Lite read address.
REQ-009 rvalid/rready  out/in  1/1, rdata  out  32, rresp  out  2: AXI-Lite read data.
REQ-010 aes_state  out  128, aes_key  out  256: operands to the AES-256 core.
REQ-011 aes_out  in  128: ciphertext from the AES-256 core.
REQ-012 done_pulse  out  1: one-cycle pulse at completion.
REQ-013 vled  out  16: ciphertext word CT0[15:0].

Function
REQ-014 Register map (byte address, 32-bit words):
- KEY0..7 at 0x00-0x1C, RW; KEY0 = key[31:0].
- PT0..3 at 0x20-0x2C, RW; PT0 = state[31:0].
- CTRL at 0x30, W: bit0 START (write-1), bit1 CLR_ERR (write-1); reads 0.
- STATUS at 0x34, RO: bit0 BUSY, bit1 DONE, bit2 ERR.
- CT0..3 at 0x40-0x4C, RO.
REQ-015 Writes honour wstrb per byte; writes to RO or unmapped addresses are dropped but still receive bvalid with bresp=0.
REQ-016 Write handshake: awready=1 only in WIDLE; aw accepted -> WDATA; wready=1 in WDATA; w accepted -> register update in the same edge and bvalid=1 next cycle; bvalid holds until bready; one write is outstanding at a time.
REQ-017 Read handshake: arready=1 only when no read is pending and rvalid=0; rvalid rises exactly 1 cycle after ar acceptance with registered rdata; rvalid holds until rready; rresp=0.
REQ-018 Operation FSM has three states:
- IDLE -> RUN on a START write; DONE cleared, counter loaded with AES_LATENCY.
- RUN: counter decrements each cycle; at 0, CT0..3 <= aes_out, done_pulse=1, -> DONE.
- DONE -> RUN on a START write; otherwise stays in DONE.
REQ-019 BUSY=1 exactly in RUN; DONE=1 from completion until the next accepted START.
REQ-020 aes_state and aes_key are driven from PT/KEY registers, which are frozen in RUN: KEY/PT writes in RUN are dropped and set ERR.
REQ-021 START written in RUN is ignored and sets ERR; ERR is sticky and clears only via CLR_ERR.
REQ-022 CLR_ERR and START in the same write: START is evaluated first, then ERR is cleared.
REQ-023 A read of STATUS in the same cycle as completion returns the pre-completion value; the next read returns DONE=1.
REQ-024 vled = CT0[15:0], registered.

Reset
REQ-025 While rst_main_n=0: FSM=IDLE; KEY/PT/CT/counter=0; ERR=DONE=0; awready=arready=0 for the reset cycle; bvalid=rvalid=done_pulse=0; rdata=0; vled=0.
REQ-026 Deassertion is synchronized by a 2-flop synchronizer; all logic uses the synchronized reset.
REQ-027 Reset mid-RUN aborts the operation: no done_pulse and CT stays 0.

Structure
REQ-028 Package aes_ocl_pkg holds the address constants, STATUS bit indices, the FSM state enum and UNIMPL_VAL.
REQ-029 One natural sub-module, aes_ocl_axil_slv (AXI-Lite handshake plus register decode), instantiated by aes_ocl_ctrl; the aes_256 core sits outside this block.

Verification
REQ-030 Write KEY=0x000102..1F and PT=0x00112233_44556677_8899AABB_CCDDEEFF, START -> done_pulse exactly AES_LATENCY+1 cycles after the w handshake; CT0..3 = 8EA2B7CA_516745BF_EAFC4990_4B496089 (FIPS-197 C.3).
REQ-031 START during RUN -> STATUS reads 0x5 (BUSY|ERR); completion is unaffected; CTRL write 0x2 -> STATUS reads 0x2.
REQ-032 PT0 write with wstrb=4'b0010, wdata=0xAABBCCDD -> PT0 reads 0x0000CC00.
REQ-033 Read 0x100 -> rdata 0xDEADBEEF; rready held low 5 cycles -> rvalid and rdata stable; arready=0 throughout.
REQ-034 Assert rst_main_n=0 at RUN cycle 10 -> after reset STATUS=0, CT0=0, no done_pulse.
